mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage: consumes EX/MEM register outputs (ALU result, store data, rd, control).
//  Performs a load or store through a req/ack data-memory port, byte-lane aligned.
//  Stalls the upstream pipeline while an access is in flight.
//  Presents the registered MEM/WB result (writeback data, rd, reg_write) to WB.
// PARAMETERS
//  ADDR_W   32  data-memory address width (low ADDR_W bits of ALU result used)
//  TIMEOUT  15  max cycles waiting for dmem_ack before bus error; 4-bit counter, must be 1..15
// PORTS
//  clk           in   1   pipeline clock; all state updates on negedge clk
//  rst_n         in   1   asynchronous, active-low reset
//  alu_in        in   32  ALU result: address for mem ops, writeback value otherwise
//  dato_B        in   32  store data
//  rd            in   5   destination register
//  reg_write     in   1   instruction writes a register
//  mem_read      in   1   load
//  mem_write     in   1   store (mem_read&mem_write both 1: treated as load)
//  mem_size      in   2   00 byte, 01 half, 10 word, 11 reserved (= word)
//  mem_unsigned  in   1   zero-extend loads (LBU/LHU)
//  dmem_req      out  1   access request, held until ack/timeout
//  dmem_we       out  1   1 = store
//  dmem_addr     out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dmem_wdata    out  32  lane-replicated store data
//  dmem_be       out  4   byte enables, little-endian
//  dmem_ack      in   1   access complete; dmem_rdata valid this cycle
//  dmem_rdata    in   32  read word
//  stall         out  1   hold PC/IF_ID/ID_EX/EX_MEM, combinational
//  wb_data       out  32  MEM/WB writeback value
//  wb_rd         out  5   MEM/WB destination
//  wb_reg_write  out  1   MEM/WB write enable
//  bus_err       out  1   one-cycle pulse: access timed out
// BEHAVIOUR
//  Reset: state IDLE; dmem_req, dmem_we, dmem_be, wb_reg_write, bus_err = 0; dmem_addr, dmem_wdata, wb_data, wb_rd = 0.
//  FSM IDLE / WAIT. mem_op = mem_read|mem_write.
//  IDLE, !mem_op: at negedge, wb_* <= {alu_in, rd, reg_write}; latency 1 edge, no stall.
//  IDLE, mem_op: stall=1; at negedge latch addr/data/be/ctl, dmem_req<=1, wb_reg_write<=0, go WAIT.
//  WAIT: stall = !dmem_ack. Upstream inputs ignored (held by stall).
//   On ack, at negedge: dmem_req<=0; load: wb_data<=extracted rdata, wb_reg_write<=reg_write;
//   store: wb_reg_write<=0; return IDLE. Upstream advances on the same edge.
//  dmem_ack in IDLE ignored. Ack always consumed, even if coincident with timeout expiry.
//  Timeout: counter clears on entering WAIT; counts each negedge in WAIT without ack;
//   reaching TIMEOUT -> dmem_req<=0, bus_err pulse, wb_data<=0, wb_reg_write<=0, IDLE.
//  Stores: byte be=4'b0001<<addr[1:0], wdata={4{B[7:0]}}; half be=addr[1]?4'b1100:4'b0011, wdata={2{B[15:0]}}; word be=4'b1111.
//  Loads: byte lane addr[1:0], half lane addr[1]; sign-extend unless mem_unsigned.
//  Reset mid-access: dmem_req drops immediately; late ack after reset ignored (IDLE).
// CONFIGURATION
//  MEM_MISALIGN_EXC_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no dmem_req,
//   no stall; adds output misalign (1 bit, reset 0, one-cycle pulse), wb_reg_write<=0.
//  Not defined: low address bits masked to the size's alignment (half: addr[0]=0, word: addr[1:0]=0); access proceeds; no misalign port.
// STRUCTURE
//  Package mem_pkg: SZ_BYTE/SZ_HALF/SZ_WORD encodings, FSM state enum, TIMEOUT counter width.
//  Sub-module mem_load_ext: combinational lane select + sign/zero extension (rdata, addr[1:0], size, unsigned -> 32b).
// TESTING
//  ALU op, alu_in=32'h1234, rd=5, reg_write=1 -> next negedge wb_data=32'h1234, wb_rd=5, stall never 1.
//  LB addr=32'h103, rdata=32'h80FF_FF7F, ack after 3 cycles -> stall 4 cycles, wb_data=32'hFFFF_FF80.
//  LHU addr=32'h102, rdata=32'h8001_0000 -> wb_data=32'h0000_8001; LH same -> 32'hFFFF_8001.
//  SB addr=32'h201, dato_B=32'hAB -> dmem_be=4'b0010, wdata=32'hABAB_ABAB, dmem_addr=32'h200, wb_reg_write=0.
//  No ack for TIMEOUT cycles -> bus_err pulse, req drops, wb_reg_write=0; rst_n low mid-WAIT -> all outputs 0 at once.
//  LW addr=32'h102: with MEM_MISALIGN_EXC_EN misalign=1, no req; without, dmem_addr=32'h100, be=4'b1111.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, FSM states, timeout counter width.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int unsigned TO_CNT_W = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_load_ext.sv
// Load data alignment: picks the addressed byte/half lane of a read word and sign/zero extends it.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_c = rdata_i[15:8];
      2'd2:    byte_c = rdata_i[23:16];
      2'd3:    byte_c = rdata_i[31:24];
      default: byte_c = rdata_i[7:0];
    endcase
    half_c = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (size_i)
      SZ_BYTE: data_o = unsigned_i ? {24'b0, byte_c} : {{24{byte_c[7]}}, byte_c};
      SZ_HALF: data_o = unsigned_i ? {16'b0, half_c} : {{16{half_c[15]}}, half_c};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-lane aligned load/store over a req/ack port with timeout, registered MEM/WB result.
// Optional MEM_MISALIGN_EXC_EN: misaligned half/word accesses are rejected with a misalign pulse.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       dato_B,
  input  logic [4:0]        rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              stall,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
`ifdef MEM_MISALIGN_EXC_EN
  output logic              misalign,
`endif
  output logic              bus_err
);

  state_e              state_q;
  logic [TO_CNT_W-1:0] cnt_q;
  logic [1:0]          lo_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic                load_q;
  logic [4:0]          rd_q;
  logic                rw_q;

  logic [ADDR_W-1:0] addr_c;
  logic [1:0]        size_c;
  logic [1:0]        lo_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic              mem_op_c;
  logic              access_c;
  logic [31:0]       ld_data_c;

  // Decode the upstream op: effective size, aligned lane offset, byte enables, replicated store data.
  always_comb begin
    addr_c   = alu_in[ADDR_W-1:0];
    mem_op_c = mem_read | mem_write;
    size_c   = (mem_size == SZ_RSVD) ? SZ_WORD : mem_size;
    lo_c     = addr_c[1:0];
    be_c     = 4'b0001 << addr_c[1:0];
    wdata_c  = {4{dato_B[7:0]}};
    case (size_c)
      SZ_HALF: begin
        lo_c    = {addr_c[1], 1'b0};
        be_c    = addr_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{dato_B[15:0]}};
      end
      SZ_WORD: begin
        lo_c    = 2'b00;
        be_c    = 4'b1111;
        wdata_c = dato_B;
      end
      default: ;
    endcase
`ifdef MEM_MISALIGN_EXC_EN
    access_c = mem_op_c &
               !(((size_c == SZ_HALF) && addr_c[0]) || ((size_c == SZ_WORD) && (addr_c[1:0] != 2'b00)));
`else
    access_c = mem_op_c;
`endif
  end

  assign stall = (state_q == S_IDLE) ? access_c : !dmem_ack;

  mem_load_ext u_load_ext (
    .rdata_i    (dmem_rdata),
    .addr_lo_i  (lo_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data_c)
  );

  // Stage FSM; everything updates on the falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lo_q         <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      load_q       <= 1'b0;
      rd_q         <= '0;
      rw_q         <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      bus_err      <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
      misalign     <= 1'b0;
`endif
    end else begin
      bus_err <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
      misalign <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (access_c) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            dmem_req     <= 1'b1;
            dmem_we      <= mem_write & !mem_read;
            dmem_addr    <= {addr_c[ADDR_W-1:2], 2'b00};
            dmem_be      <= be_c;
            dmem_wdata   <= wdata_c;
            lo_q         <= lo_c;
            size_q       <= size_c;
            uns_q        <= mem_unsigned;
            load_q       <= mem_read;
            rd_q         <= rd;
            rw_q         <= reg_write;
            wb_reg_write <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
          end else if (mem_op_c) begin
            misalign     <= 1'b1;
            wb_data      <= '0;
            wb_rd        <= rd;
            wb_reg_write <= 1'b0;
`endif
          end else begin
            wb_data      <= alu_in;
            wb_rd        <= rd;
            wb_reg_write <= reg_write;
          end
        end
        S_WAIT: begin
          // An ack always wins over a coincident timeout.
          if (dmem_ack) begin
            state_q      <= S_IDLE;
            dmem_req     <= 1'b0;
            wb_rd        <= rd_q;
            wb_reg_write <= load_q & rw_q;
            if (load_q) wb_data <= ld_data_c;
          end else if (cnt_q == TO_CNT_W'(TIMEOUT - 1)) begin
            state_q      <= S_IDLE;
            dmem_req     <= 1'b0;
            bus_err      <= 1'b1;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
          end else begin
            cnt_q <= cnt_q + TO_CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (negedge-clocked MEM stage with req/ack data port).
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_in;
  logic [31:0] dato_B;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        bus_err;
`ifdef MEM_MISALIGN_EXC_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;
  int stalls;

  mem_stage #(.ADDR_W(32), .TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_in       (alu_in),
    .dato_B       (dato_B),
    .rd           (rd),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .stall        (stall),
    .wb_data      (wb_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
`ifdef MEM_MISALIGN_EXC_EN
    .misalign     (misalign),
`endif
    .bus_err      (bus_err)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Land 1 time unit after the rising edge; the DUT's falling edge is 4 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                        input logic rw, input logic mr, input logic mw,
                        input logic [1:0] sz, input logic u);
    alu_in = a; dato_B = b; rd = r; reg_write = rw;
    mem_read = mr; mem_write = mw; mem_size = sz; mem_unsigned = u;
  endtask

  task automatic bubble();
    set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  // Present a memory op, let it enter WAIT, then show a bubble upstream.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                       input logic rw, input logic mr, input logic mw,
                       input logic [1:0] sz, input logic u);
    set_op(a, b, r, rw, mr, mw, sz, u);
    tick();
    bubble();
  endtask

  task automatic complete(input int n_wait, input logic [31:0] rdata);
    repeat (n_wait) tick();
    dmem_ack = 1'b1;
    dmem_rdata = rdata;
    tick();
    dmem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bubble();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_we", 32'(wb_reg_write), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    rst_n = 1'b1;

    // ALU passthrough
    set_op(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    #1;
    chk("alu_stall", 32'(stall), 32'd0);
    tick();
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_rd", 32'(wb_rd), 32'd5);
    chk("alu_wb_we", 32'(wb_reg_write), 32'd1);

    // LB 0x103, ack after 3 WAIT cycles
    stalls = 0;
    set_op(32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    #1;
    if (stall) stalls++;
    tick();
    bubble();
    chk("lb_req", 32'(dmem_req), 32'd1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_be", 32'(dmem_be), 32'b1000);
    chk("lb_we", 32'(dmem_we), 32'd0);
    chk("lb_wb_we_wait", 32'(wb_reg_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (stall) stalls++;
      tick();
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h80FF_FF7F;
    #1;
    if (stall) stalls++;
    tick();
    dmem_ack = 1'b0;
    chk("lb_stalls", 32'(stalls), 32'd4);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_wb_rd", 32'(wb_rd), 32'd7);
    chk("lb_wb_we", 32'(wb_reg_write), 32'd1);
    chk("lb_req_drop", 32'(dmem_req), 32'd0);

    // LHU / LH 0x102
    issue(32'h102, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
    chk("lhu_be", 32'(dmem_be), 32'b1100);
    complete(1, 32'h8001_0000);
    chk("lhu_wb_data", wb_data, 32'h0000_8001);
    chk("lhu_wb_we", 32'(wb_reg_write), 32'd1);
    issue(32'h102, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
    complete(2, 32'h8001_0000);
    chk("lh_wb_data", wb_data, 32'hFFFF_8001);

    // SB 0x201
    issue(32'h201, 32'hAB, 5'd9, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    chk("sb_be", 32'(dmem_be), 32'b0010);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", dmem_addr, 32'h200);
    chk("sb_we", 32'(dmem_we), 32'd1);
    complete(0, 32'h0);
    chk("sb_wb_we", 32'(wb_reg_write), 32'd0);
    chk("sb_req_drop", 32'(dmem_req), 32'd0);

    // Timeout: 15 ack-less falling edges in WAIT
    set_op(32'h5555, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    tick();
    chk("to_pre_wb", wb_data, 32'h5555);
    issue(32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    repeat (14) tick();
    chk("to_req_held", 32'(dmem_req), 32'd1);
    chk("to_no_err_yet", 32'(bus_err), 32'd0);
    tick();
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_wb_data", wb_data, 32'd0);
    chk("to_wb_we", 32'(wb_reg_write), 32'd0);
    chk("to_stall", 32'(stall), 32'd0);
    tick();
    chk("to_pulse_end", 32'(bus_err), 32'd0);

    // Reset in the middle of WAIT, then a late ack
    set_op(32'h7777, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    tick();
    issue(32'h400, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_req", 32'(dmem_req), 32'd0);
    chk("mrst_addr", dmem_addr, 32'd0);
    chk("mrst_wb_data", wb_data, 32'd0);
    chk("mrst_wb_we", 32'(wb_reg_write), 32'd0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    tick();
    rst_n = 1'b1;
    #1;
    chk("late_ack_stall", 32'(stall), 32'd0);
    tick();
    chk("late_ack_req", 32'(dmem_req), 32'd0);
    chk("late_ack_wb_we", 32'(wb_reg_write), 32'd0);
    dmem_ack = 1'b0;

    // LW 0x102 (misaligned word)
`ifdef MEM_MISALIGN_EXC_EN
    set_op(32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    #1;
    chk("mis_stall", 32'(stall), 32'd0);
    tick();
    bubble();
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_no_req", 32'(dmem_req), 32'd0);
    chk("mis_wb_we", 32'(wb_reg_write), 32'd0);
    tick();
    chk("mis_pulse_end", 32'(misalign), 32'd0);
`else
    issue(32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    chk("lw_mask_addr", dmem_addr, 32'h100);
    chk("lw_mask_be", 32'(dmem_be), 32'b1111);
    chk("lw_mask_req", 32'(dmem_req), 32'd1);
    complete(0, 32'hDEAD_BEEF);
    chk("lw_mask_data", wb_data, 32'hDEAD_BEEF);
    chk("lw_mask_rd", 32'(wb_rd), 32'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
